// File: rtl/input_p4_interface_demux.sv
// input_p4_interface_demux
// Steers whole packets from the arbiter's single AXI4-Stream onto one of up
// to five virtual-switch streams, selected by the VID field of the first-beat
// tuser. Packets with an out-of-range VID are swallowed and counted.
module input_p4_interface_demux #(
    parameter int NUM_QUEUES           = 3,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int VID_LSB              = 32,
    parameter int VID_WIDTH            = 8
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    output logic                              m_axis_0_tlast,
    input  logic                              m_axis_0_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    output logic                              m_axis_1_tlast,
    input  logic                              m_axis_1_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
    output logic                              m_axis_2_tvalid,
    output logic                              m_axis_2_tlast,
    input  logic                              m_axis_2_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
    output logic                              m_axis_3_tvalid,
    output logic                              m_axis_3_tlast,
    input  logic                              m_axis_3_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_4_tuser,
    output logic                              m_axis_4_tvalid,
    output logic                              m_axis_4_tlast,
    input  logic                              m_axis_4_tready,

    output logic                              pkt_in,
    output logic [31:0]                       drop_count
);

    localparam int MAX_Q  = 5;
    localparam int DW     = C_M_AXIS_DATA_WIDTH;
    localparam int KW     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_M_AXIS_TUSER_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]        state;
    logic [2:0]        dest;

    logic [31:0]       vid_ext;
    logic              vid_ok;
    logic [2:0]        sel;
    logic              fwd_beat;
    logic              ready_int;
    logic              handshake;
    logic              first_fwd;
    logic              first_drop;

    logic [7:0]        out_ready;
    logic [MAX_Q-1:0]  out_valid;
    logic [MAX_Q-1:0]  out_last;
    logic [MAX_Q-1:0]  m_tready;
    logic [MAX_Q-1:0]  load;
    logic [DW-1:0]     out_data [MAX_Q];
    logic [KW-1:0]     out_keep [MAX_Q];
    logic [UW-1:0]     out_user [MAX_Q];

    assign vid_ext  = 32'(s_axis_tuser[VID_LSB +: VID_WIDTH]);
    assign vid_ok   = (vid_ext < 32'(NUM_QUEUES));

    assign m_tready = {m_axis_4_tready, m_axis_3_tready, m_axis_2_tready,
                       m_axis_1_tready, m_axis_0_tready};

    // An output slot can accept a beat when empty or draining this cycle.
    assign out_ready = {3'b000, (~out_valid | m_tready)};

    // Pick the target output and ingress readiness from the current state.
    always_comb begin
        sel       = dest;
        fwd_beat  = 1'b0;
        ready_int = 1'b0;
        case (state)
            IDLE: begin
                if (vid_ok) begin
                    sel       = vid_ext[2:0];
                    fwd_beat  = 1'b1;
                    ready_int = out_ready[vid_ext[2:0]];
                end else begin
                    ready_int = 1'b1;
                end
            end
            FWD: begin
                sel       = dest;
                fwd_beat  = 1'b1;
                ready_int = out_ready[dest];
            end
            DROP: begin
                ready_int = 1'b1;
            end
            default: begin
                ready_int = 1'b0;
            end
        endcase
    end

    assign s_axis_tready = ready_int & ~axis_reset;
    assign handshake     = s_axis_tvalid & s_axis_tready;
    assign first_fwd     = handshake & (state == IDLE) & vid_ok;
    assign first_drop    = handshake & (state == IDLE) & ~vid_ok;

    // Packet-level state machine: remembers the destination until tlast.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state <= IDLE;
            dest  <= 3'd0;
        end else if (handshake) begin
            case (state)
                IDLE: begin
                    if (vid_ok) begin
                        dest  <= sel;
                        state <= s_axis_tlast ? IDLE : FWD;
                    end else begin
                        state <= s_axis_tlast ? IDLE : DROP;
                    end
                end
                FWD: begin
                    if (s_axis_tlast) state <= IDLE;
                end
                DROP: begin
                    if (s_axis_tlast) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-cycle pulse for every packet that starts forwarding.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            pkt_in <= 1'b0;
        end else begin
            pkt_in <= first_fwd;
        end
    end

    // Saturating count of packets discarded for an invalid VID.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            drop_count <= 32'd0;
        end else if (first_drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < MAX_Q; k++) begin : g_out
            assign load[k] = handshake & fwd_beat & (sel == 3'(k));

            // Valid flag of the output slot: set on load, cleared on drain.
            always_ff @(posedge axis_aclk) begin
                if (axis_reset) begin
                    out_valid[k] <= 1'b0;
                end else if (load[k]) begin
                    out_valid[k] <= 1'b1;
                end else if (m_tready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end

            // Payload of the output slot; only changes when a new beat loads.
            always_ff @(posedge axis_aclk) begin
                if (load[k]) begin
                    out_data[k] <= s_axis_tdata;
                    out_keep[k] <= s_axis_tkeep;
                    out_user[k] <= s_axis_tuser;
                    out_last[k] <= s_axis_tlast;
                end
            end
        end
    endgenerate

    assign m_axis_0_tdata  = out_data[0];
    assign m_axis_0_tkeep  = out_keep[0];
    assign m_axis_0_tuser  = out_user[0];
    assign m_axis_0_tvalid = out_valid[0];
    assign m_axis_0_tlast  = out_last[0];

    assign m_axis_1_tdata  = out_data[1];
    assign m_axis_1_tkeep  = out_keep[1];
    assign m_axis_1_tuser  = out_user[1];
    assign m_axis_1_tvalid = out_valid[1];
    assign m_axis_1_tlast  = out_last[1];

    assign m_axis_2_tdata  = out_data[2];
    assign m_axis_2_tkeep  = out_keep[2];
    assign m_axis_2_tuser  = out_user[2];
    assign m_axis_2_tvalid = out_valid[2];
    assign m_axis_2_tlast  = out_last[2];

    assign m_axis_3_tdata  = out_data[3];
    assign m_axis_3_tkeep  = out_keep[3];
    assign m_axis_3_tuser  = out_user[3];
    assign m_axis_3_tvalid = out_valid[3];
    assign m_axis_3_tlast  = out_last[3];

    assign m_axis_4_tdata  = out_data[4];
    assign m_axis_4_tkeep  = out_keep[4];
    assign m_axis_4_tuser  = out_user[4];
    assign m_axis_4_tvalid = out_valid[4];
    assign m_axis_4_tlast  = out_last[4];

endmodule

// File: tb/tb_input_p4_interface_demux.sv
// Testbench for input_p4_interface_demux: random packets are routed by a
// simple queue-per-output model and every delivered beat is scoreboarded.
module tb_input_p4_interface_demux;

    localparam int NQ = 3;
    typedef logic [592:0] beat_t;

    logic         axis_aclk = 1'b0;
    logic         axis_reset = 1'b1;
    logic [255:0] s_data = '0;
    logic [31:0]  s_keep = '0;
    logic [303:0] s_user = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    wire          s_ready;
    logic [4:0]   m_ready = 5'b11111;

    wire  [255:0] m_data [5];
    wire  [31:0]  m_keep [5];
    wire  [303:0] m_user [5];
    wire  [4:0]   m_valid;
    wire  [4:0]   m_last;
    wire          pkt_in;
    wire  [31:0]  drop_count;

    int      n_tests = 0;
    int      n_fail = 0;
    int      cyc = 0;
    bit      rand_ready = 1'b0;
    beat_t   exp_q [5][$];
    int      rx_cnt [5];
    int      exp_pkts = 0;
    int      pkt_cnt = 0;
    longint  exp_drops = 0;
    int      stall_viol = 0;
    int      hi_valid_cnt = 0;
    bit      prev_stalled [5];
    beat_t   prev_beat [5];

    logic [4:0]  snap_valid;
    logic        snap_pkt_in;
    logic        snap_sready;
    logic [31:0] snap_drop;

    always #5 axis_aclk = ~axis_aclk;

    input_p4_interface_demux #(.NUM_QUEUES(NQ)) dut (
        .axis_aclk(axis_aclk), .axis_reset(axis_reset),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user),
        .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_0_tdata(m_data[0]), .m_axis_0_tkeep(m_keep[0]), .m_axis_0_tuser(m_user[0]),
        .m_axis_0_tvalid(m_valid[0]), .m_axis_0_tlast(m_last[0]), .m_axis_0_tready(m_ready[0]),
        .m_axis_1_tdata(m_data[1]), .m_axis_1_tkeep(m_keep[1]), .m_axis_1_tuser(m_user[1]),
        .m_axis_1_tvalid(m_valid[1]), .m_axis_1_tlast(m_last[1]), .m_axis_1_tready(m_ready[1]),
        .m_axis_2_tdata(m_data[2]), .m_axis_2_tkeep(m_keep[2]), .m_axis_2_tuser(m_user[2]),
        .m_axis_2_tvalid(m_valid[2]), .m_axis_2_tlast(m_last[2]), .m_axis_2_tready(m_ready[2]),
        .m_axis_3_tdata(m_data[3]), .m_axis_3_tkeep(m_keep[3]), .m_axis_3_tuser(m_user[3]),
        .m_axis_3_tvalid(m_valid[3]), .m_axis_3_tlast(m_last[3]), .m_axis_3_tready(m_ready[3]),
        .m_axis_4_tdata(m_data[4]), .m_axis_4_tkeep(m_keep[4]), .m_axis_4_tuser(m_user[4]),
        .m_axis_4_tvalid(m_valid[4]), .m_axis_4_tlast(m_last[4]), .m_axis_4_tready(m_ready[4]),
        .pkt_in(pkt_in), .drop_count(drop_count)
    );

    // Observes outputs on the falling edge: scoreboard, stability, pulses.
    task automatic sample();
        beat_t cur;
        beat_t e;
        for (int k = 0; k < 5; k++) begin
            cur = {m_last[k], m_user[k], m_keep[k], m_data[k]};
            if (k >= NQ && m_valid[k]) hi_valid_cnt++;
            if (prev_stalled[k] && (!m_valid[k] || cur !== prev_beat[k])) stall_viol++;
            prev_stalled[k] = m_valid[k] && !m_ready[k] && !axis_reset;
            prev_beat[k] = cur;
            if (m_valid[k] && m_ready[k] && !axis_reset) begin
                rx_cnt[k]++;
                n_tests++;
                if (exp_q[k].size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat_out%0d got tdata %h, required no beat", k, m_data[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("[TB] FAIL beat_out%0d got %h required %h", k, cur, e);
                    end
                end
            end
        end
        if (pkt_in) pkt_cnt++;
        snap_valid  = m_valid;
        snap_pkt_in = pkt_in;
        snap_sready = s_ready;
        snap_drop   = drop_count;
    endtask

    // Advances one clock; inputs change 1 time unit after the rising edge.
    task automatic cycle(output bit hs);
        @(negedge axis_aclk);
        sample();
        hs = s_valid && s_ready;
        @(posedge axis_aclk);
        #1;
        if (rand_ready) begin
            for (int b = 0; b < 5; b++) m_ready[b] = ($urandom_range(0, 3) != 0);
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        bit hs;
        rand_ready = 1'b0;
        m_ready = 5'b11111;
        s_valid = 1'b0;
        repeat (n) cycle(hs);
    endtask

    // Drives one packet and updates the routing model.
    task automatic send_pkt(input int vid, input int nbeats, input bit gaps, input int stall,
                            output int cycles_used, output int stall_open);
        logic [319:0] w;
        bit hs;
        int guard;
        cycles_used = 0;
        stall_open = 0;
        if (vid < NQ) exp_pkts++;
        else exp_drops = (exp_drops < 64'hFFFF_FFFF) ? exp_drops + 1 : 64'hFFFF_FFFF;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    cycle(hs);
                end
            end
            for (int j = 0; j < 10; j++) w[j*32 +: 32] = $urandom;
            s_data = w[255:0];
            s_keep = $urandom;
            for (int j = 0; j < 10; j++) w[j*32 +: 32] = $urandom;
            s_user = w[303:0];
            if (i == 0) s_user[32 +: 8] = vid[7:0];
            s_last = (i == nbeats - 1);
            s_valid = 1'b1;
            guard = 0;
            hs = 1'b0;
            while (!hs && guard < 500) begin
                cycle(hs);
                cycles_used++;
                guard++;
            end
            if (!hs) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL handshake_timeout got no handshake in %0d cycles, required one", guard);
            end else if (vid < NQ) begin
                exp_q[vid].push_back({s_last, s_user, s_keep, s_data});
            end
            if (i == 0 && stall > 0) begin
                s_valid = 1'b0;
                m_ready[vid] = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    cycle(hs);
                    if (snap_sready) stall_open++;
                end
                m_ready[vid] = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic test_reset();
        bit hs;
        axis_reset = 1'b1;
        repeat (3) cycle(hs);
        n_tests++;
        if (snap_sready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_tready got %b required 0", snap_sready);
        end
        axis_reset = 1'b0;
        cycle(hs);
        n_tests++;
        if (snap_valid !== 5'b0 || snap_pkt_in !== 1'b0 || snap_drop !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got valid=%b pkt_in=%b drop=%0d required 0/0/0",
                     snap_valid, snap_pkt_in, snap_drop);
        end
    endtask

    task automatic test_single_beat();
        int cu, so;
        bit hs;
        drain(2);
        send_pkt(1, 1, 1'b0, 0, cu, so);
        cycle(hs);
        n_tests++;
        if (snap_valid !== 5'b00010 || snap_pkt_in !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_latency got valid=%b pkt_in=%b required 00010/1", snap_valid, snap_pkt_in);
        end
        cycle(hs);
        n_tests++;
        if (snap_valid !== 5'b0 || snap_pkt_in !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_after got valid=%b pkt_in=%b required 00000/0", snap_valid, snap_pkt_in);
        end
        n_tests++;
        if (rx_cnt[1] !== 1 || pkt_cnt !== exp_pkts) begin
            n_fail++;
            $display("[TB] FAIL single_count got rx1=%0d pkts=%0d required 1/%0d", rx_cnt[1], pkt_cnt, exp_pkts);
        end
    endtask

    task automatic test_backpressure();
        int cu, so, base;
        base = rx_cnt[2];
        send_pkt(2, 4, 1'b0, 3, cu, so);
        drain(4);
        n_tests++;
        if (so !== 0) begin
            n_fail++;
            $display("[TB] FAIL bp_tready got %0d ready cycles during stall, required 0", so);
        end
        n_tests++;
        if (rx_cnt[2] - base !== 4 || exp_q[2].size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL bp_delivery got %0d beats (%0d pending) required 4 (0)",
                     rx_cnt[2] - base, exp_q[2].size());
        end
    endtask

    task automatic test_back_to_back();
        int cu, so, total, pk0;
        int vids [4] = '{0, 1, 2, 0};
        total = 0;
        pk0 = pkt_cnt;
        for (int p = 0; p < 4; p++) begin
            send_pkt(vids[p], 2, 1'b0, 0, cu, so);
            total += cu;
        end
        drain(4);
        n_tests++;
        if (total !== 8) begin
            n_fail++;
            $display("[TB] FAIL b2b_cycles got %0d required 8", total);
        end
        n_tests++;
        if (pkt_cnt - pk0 !== 4 || exp_q[0].size() + exp_q[1].size() + exp_q[2].size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_pkts got %0d pulses required 4", pkt_cnt - pk0);
        end
    endtask

    task automatic test_drop();
        int cu, so, base;
        bit hs;
        send_pkt(7, 3, 1'b0, 0, cu, so);
        cycle(hs);
        n_tests++;
        if (cu !== 3 || snap_valid !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL drop_path got cycles=%0d valid=%b required 3/00000", cu, snap_valid);
        end
        n_tests++;
        if (snap_drop !== exp_drops[31:0] || snap_drop !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL drop_count got %0d required %0d", snap_drop, exp_drops);
        end
        base = rx_cnt[0];
        send_pkt(0, 2, 1'b0, 0, cu, so);
        drain(4);
        n_tests++;
        if (rx_cnt[0] - base !== 2 || pkt_cnt !== exp_pkts) begin
            n_fail++;
            $display("[TB] FAIL drop_then_fwd got %0d beats pkts=%0d required 2/%0d",
                     rx_cnt[0] - base, pkt_cnt, exp_pkts);
        end
    endtask

    task automatic test_saturation();
        int cu, so;
        bit hs;
        force dut.drop_count = 32'hFFFF_FFFE;
        cycle(hs);
        release dut.drop_count;
        exp_drops = 64'hFFFF_FFFE;
        cycle(hs);
        for (int p = 0; p < 3; p++) send_pkt(5 + p, 2, 1'b0, 0, cu, so);
        cycle(hs);
        n_tests++;
        if (snap_drop !== exp_drops[31:0] || snap_drop !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL saturation got %h required %h", snap_drop, exp_drops[31:0]);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cu, so, base, guard;
        bit hs;
        m_ready = 5'b00000;
        s_data = {8{$urandom}};
        s_keep = $urandom;
        s_user = '0;
        s_user[32 +: 8] = 8'd1;
        s_last = 1'b0;
        s_valid = 1'b1;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 50) begin
            cycle(hs);
            guard++;
        end
        exp_pkts++;
        axis_reset = 1'b1;
        s_data = {8{$urandom}};
        cycle(hs);
        n_tests++;
        if (snap_sready !== 1'b0 || hs !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_tready got %b required 0", snap_sready);
        end
        axis_reset = 1'b0;
        s_valid = 1'b0;
        exp_drops = 0;
        cycle(hs);
        n_tests++;
        if (snap_valid !== 5'b0 || snap_drop !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_state got valid=%b drop=%0d required 00000/0", snap_valid, snap_drop);
        end
        m_ready = 5'b11111;
        base = rx_cnt[0];
        send_pkt(0, 3, 1'b0, 0, cu, so);
        drain(4);
        n_tests++;
        if (rx_cnt[0] - base !== 3 || exp_q[0].size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_next got %0d beats on out0 required 3", rx_cnt[0] - base);
        end
    endtask

    task automatic test_random();
        int cu, so, v, pending;
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 255) : $urandom_range(0, 7);
            send_pkt(v, $urandom_range(1, 6), 1'b1, 0, cu, so);
        end
        drain(6);
        pending = 0;
        for (int k = 0; k < 5; k++) pending += exp_q[k].size();
        n_tests++;
        if (pending !== 0) begin
            n_fail++;
            $display("[TB] FAIL random_pending got %0d undelivered beats required 0", pending);
        end
        n_tests++;
        if (pkt_cnt !== exp_pkts) begin
            n_fail++;
            $display("[TB] FAIL random_pkt_in got %0d required %0d", pkt_cnt, exp_pkts);
        end
        n_tests++;
        if (drop_count !== exp_drops[31:0]) begin
            n_fail++;
            $display("[TB] FAIL random_drops got %0d required %0d", drop_count, exp_drops);
        end
        n_tests++;
        if (stall_viol !== 0 || hi_valid_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL random_axi_rules got stall_viol=%0d hi_valid=%0d required 0/0",
                     stall_viol, hi_valid_cnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rx_cnt[k] = 0;
            prev_stalled[k] = 1'b0;
            prev_beat[k] = '0;
        end
        test_reset();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_saturation();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
